// File: rtl/csm51a_sweep_checker_if.sv
// Handshake and result bundle between a sweep checker and the logic that starts it.
// The slave side is the checker; the master side starts sweeps, closes the loop on z and reads results.
interface csm51a_sweep_checker_if #(
  parameter int unsigned N_IN = 3
);
  logic                   start;
  logic                   z;
  logic [N_IN-1:0]        x;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   fail_mask;
  logic [N_IN:0]          fail_count;

  modport master (
    output start, z,
    input  x, busy, done, pass, fail_mask, fail_count
  );

  modport slave (
    input  start, z,
    output x, busy, done, pass, fail_mask, fail_count
  );
endinterface

// File: rtl/csm51a_sweep_checker.sv
// Exhaustive truth-table sweep checker: walks every input code through the block under test,
// holds each code for a settle window, samples z and records mismatches against EXPECTED.
module csm51a_sweep_checker #(
  parameter int unsigned          N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'b1001_0110,
  parameter int unsigned          SETTLE   = 4
) (
  input logic                   clk,
  input logic                   rst,
  csm51a_sweep_checker_if.slave bus
);

  localparam int unsigned       N_CODES  = 1 << N_IN;
  localparam int unsigned       CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     LAST_CNT = CW'(SETTLE - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0]   LAST_IDX = N_IN'(N_CODES - 1);
  localparam logic [N_IN-1:0]   IDX_ONE  = N_IN'(1);
  localparam logic [N_IN:0]     FC_ONE   = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_CODES-1:0]  mask_q, mask_d;
  logic [N_IN:0]       count_q, count_d;
  logic                pass_q, pass_d;
  logic [N_IN-1:0]     x_q, x_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                last_code;
  logic                mismatch;

  assign last_code = (idx_q == LAST_IDX);
  assign mismatch  = (bus.z != EXPECTED[idx_q]);

  // NOTE: every clocked process uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: each always_comb assigns a default to every output first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == LAST_CNT) state_d = S_SAMPLE;
      S_SAMPLE: state_d = last_code ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: code index, settle counter and the result accumulators.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    count_d = count_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          cnt_d   = '0;
          mask_d  = '0;
          count_d = '0;
          pass_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q != LAST_CNT) cnt_d = cnt_q + CNT_ONE;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          count_d       = count_q + FC_ONE;
        end
        if (last_code) begin
          // pass must see the final code's mismatch, so it is taken from count_d.
          pass_d = (count_d == '0);
        end else begin
          idx_d = idx_q + IDX_ONE;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output decode from the next state, so the visible outputs come straight off flops.
  always_comb begin
    x_d    = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_SETTLE, S_SAMPLE: begin
        x_d    = idx_d;
        busy_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      pass_q  <= 1'b0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = mask_q;
  assign bus.fail_count = count_q;

endmodule
